pipe_mult_param: RTL and testbench

//  Parametrised pipelined integer multiplier for the multiplier tile family.

---
 rtl/pipe_mult_param.sv | 120 ++++++++++++
 tb/tb_pipe_mult_param.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_mult_param.sv
// Parametrised pipelined signed/unsigned integer multiplier with valid/ready on both sides.
// Each register stage folds one WIDTH/STAGES-bit slice of the multiplier into a 2*WIDTH accumulator.

module pipe_mult_stage #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2,
   parameter int K      = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               advance,
   input  logic               d_vld,
   input  logic               d_sgn,
   input  logic [2*WIDTH-1:0] d_a,
   input  logic [WIDTH-1:0]   d_b,
   input  logic [2*WIDTH-1:0] d_acc,
   output logic               q_vld,
   output logic               q_sgn,
   output logic [2*WIDTH-1:0] q_a,
   output logic [WIDTH-1:0]   q_b,
   output logic [2*WIDTH-1:0] q_acc
);
   localparam int AW = 2 * WIDTH;
   localparam int CH = WIDTH / STAGES;

   logic [AW-1:0] chunk_ext;
   logic [AW-1:0] acc_sum;
   logic          neg;

   assign chunk_ext = {{(AW-CH){1'b0}}, d_b[K*CH +: CH]};
   // The multiplier MSB was added with weight +2^(W-1); in signed mode it is -2^(W-1),
   // so the final stage removes a<<W to correct it.
   assign neg       = (K == STAGES - 1) && d_sgn && d_b[WIDTH-1];
   assign acc_sum   = d_acc + ((d_a * chunk_ext) << (K*CH)) - (neg ? (d_a << WIDTH) : '0);

   // Data only loads with a valid transaction so the output holds its last result across bubbles.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_vld <= 1'b0;
         q_sgn <= 1'b0;
         q_a   <= '0;
         q_b   <= '0;
         q_acc <= '0;
      end else if (advance) begin
         q_vld <= d_vld;
         if (d_vld) begin
            q_sgn <= d_sgn;
            q_a   <= d_a;
            q_b   <= d_b;
            q_acc <= acc_sum;
         end
      end
   end
endmodule

module pipe_mult_param #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic               in_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_product,
   output logic               out_signed,
   output logic               busy
);
   localparam int AW = 2 * WIDTH;

   if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
      $error("pipe_mult_param: WIDTH must be >= 2 and divisible by STAGES");
   end

   logic                         advance;
   logic [STAGES:0]              vld_pipe;
   logic [STAGES:0]              sgn_pipe;
   logic [STAGES:0][AW-1:0]      a_pipe;
   logic [STAGES:0][AW-1:0]      acc_pipe;
   logic [STAGES:0][WIDTH-1:0]   b_pipe;
   logic                         unused_tail;

   // Global stall: the whole pipe moves only when the output slot is free or draining.
   assign advance     = ~vld_pipe[STAGES] | out_ready;
   assign in_ready    = advance;

   assign vld_pipe[0] = in_valid;
   assign sgn_pipe[0] = in_signed;
   assign a_pipe[0]   = {{WIDTH{in_signed & in_a[WIDTH-1]}}, in_a};
   assign b_pipe[0]   = in_b;
   assign acc_pipe[0] = '0;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      pipe_mult_stage #(.WIDTH(WIDTH), .STAGES(STAGES), .K(k)) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .advance (advance),
         .d_vld   (vld_pipe[k]),
         .d_sgn   (sgn_pipe[k]),
         .d_a     (a_pipe[k]),
         .d_b     (b_pipe[k]),
         .d_acc   (acc_pipe[k]),
         .q_vld   (vld_pipe[k+1]),
         .q_sgn   (sgn_pipe[k+1]),
         .q_a     (a_pipe[k+1]),
         .q_b     (b_pipe[k+1]),
         .q_acc   (acc_pipe[k+1])
      );
   end

   assign out_valid   = vld_pipe[STAGES];
   assign out_product = acc_pipe[STAGES];
   assign out_signed  = sgn_pipe[STAGES];
   assign busy        = |vld_pipe[STAGES:1];
   assign unused_tail = ^{a_pipe[STAGES], b_pipe[STAGES]};
endmodule

// File: tb/tb_pipe_mult_param.sv
// Directed bench for pipe_mult_param: a 4x4/2-stage instance for the directed cases
// and an 8x8/4-stage instance driven with random stalls against a behavioural product model.

module tb_pipe_mult_param;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       a_in_valid, a_in_ready, a_in_signed, a_out_valid, a_out_ready, a_out_signed, a_busy;
   logic [3:0] a_in_a, a_in_b;
   logic [7:0] a_out_product;

   logic        b_in_valid, b_in_ready, b_in_signed, b_out_valid, b_out_ready, b_out_signed, b_busy;
   logic [7:0]  b_in_a, b_in_b;
   logic [15:0] b_out_product;

   pipe_mult_param #(.WIDTH(4), .STAGES(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_a(a_in_a), .in_b(a_in_b), .in_signed(a_in_signed), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .out_product(a_out_product), .out_signed(a_out_signed), .busy(a_busy)
   );

   pipe_mult_param #(.WIDTH(8), .STAGES(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_a(b_in_a), .in_b(b_in_b), .in_signed(b_in_signed), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_product(b_out_product), .out_signed(b_out_signed), .busy(b_busy)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic [8:0] a_got[$];
   int         a_cyc_q[$];
   logic [16:0] b_exp[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Results of the small instance are logged at the negedge before the emitting edge.
   always @(negedge clk)
      if (rst_n && a_out_valid && a_out_ready) begin
         a_got.push_back({a_out_signed, a_out_product});
         a_cyc_q.push_back(cyc);
      end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic a_send(input logic [3:0] a, input logic [3:0] b, input logic s);
      int k;
      a_in_a = a; a_in_b = b; a_in_signed = s; a_in_valid = 1'b1;
      for (k = 0; k < 50 && !a_in_ready; k++) step();
      if (k >= 50) chk("a_send_timeout", 64'(k), 64'(0));
      step();
      a_in_valid = 1'b0;
   endtask

   function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
      int x, y, p;
      logic [31:0] pv;
      x = s ? {{24{a[7]}}, a} : {24'b0, a};
      y = s ? {{24{b[7]}}, b} : {24'b0, b};
      p = x * y;
      pv = p;
      return {s, pv[15:0]};
   endfunction

   initial begin
      int acc_n;
      logic accept;
      a_in_valid = 0; a_in_a = 0; a_in_b = 0; a_in_signed = 0; a_out_ready = 1;
      b_in_valid = 0; b_in_a = 0; b_in_b = 0; b_in_signed = 0; b_out_ready = 1;
      step(2);
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_product", a_out_product, 0);
      chk("rst_in_ready", a_in_ready, 1);
      rst_n = 1'b1;
      step();

      // 15*15 unsigned: two-cycle latency, then product holds over the bubble
      a_in_a = 4'd15; a_in_b = 4'd15; a_in_signed = 0; a_in_valid = 1;
      step();
      a_in_valid = 0;
      chk("t1_not_yet", a_out_valid, 0);
      chk("t1_busy", a_busy, 1);
      step();
      chk("t1_valid", a_out_valid, 1);
      chk("t1_product", a_out_product, 8'hE1);
      step();
      chk("t1_bubble_valid", a_out_valid, 0);
      chk("t1_bubble_hold", a_out_product, 8'hE1);
      chk("t1_idle_busy", a_busy, 0);

      // signed corner cases
      a_got.delete(); a_cyc_q.delete();
      a_send(4'h8, 4'h7, 1);
      a_send(4'h8, 4'h8, 1);
      step(4);
      chk("t2_count", a_got.size(), 2);
      chk("t2_neg56", a_got[0], {1'b1, 8'hC8});
      chk("t2_minmin", a_got[1], {1'b1, 8'h40});

      // back-to-back squares
      a_got.delete(); a_cyc_q.delete();
      for (int i = 1; i <= 6; i++) a_send(4'(i), 4'(i), 0);
      step(4);
      chk("t3_count", a_got.size(), 6);
      for (int i = 0; i < 6 && i < a_got.size(); i++) begin
         chk("t3_square", a_got[i], 9'((i + 1) * (i + 1)));
         if (i > 0) chk("t3_consecutive", 64'(a_cyc_q[i] - a_cyc_q[i-1]), 64'(1));
      end

      // fill, stall five cycles, release with a simultaneous accept/emit
      a_got.delete(); a_cyc_q.delete();
      a_out_ready = 0;
      a_send(4'd2, 4'd3, 0);
      a_send(4'd5, 4'd5, 0);
      a_in_a = 4'd7; a_in_b = 4'd7; a_in_signed = 0; a_in_valid = 1;
      for (int i = 0; i < 5; i++) begin
         chk("t4_in_ready", a_in_ready, 0);
         chk("t4_out_valid", a_out_valid, 1);
         chk("t4_frozen", {a_out_signed, a_out_product}, {1'b0, 8'd6});
         step();
      end
      a_out_ready = 1;
      #1;
      chk("t4_release_ready", a_in_ready, 1);
      step();
      a_in_valid = 0;
      step(4);
      chk("t4_count", a_got.size(), 3);
      chk("t4_first", a_got[0], 9'd6);
      chk("t4_second", a_got[1], 9'd25);
      chk("t4_third", a_got[2], 9'd49);

      // reset with two transactions in flight
      a_got.delete(); a_cyc_q.delete();
      a_out_ready = 0;
      a_send(4'd3, 4'd3, 0);
      a_send(4'd4, 4'd4, 0);
      rst_n = 0;
      step();
      chk("t5_out_valid", a_out_valid, 0);
      chk("t5_busy", a_busy, 0);
      chk("t5_product", a_out_product, 0);
      rst_n = 1;
      a_out_ready = 1;
      step(6);
      chk("t5_no_stale", a_got.size(), 0);

      // 8x8 / 4 stages: random mode, operands, input gaps and output stalls
      acc_n = 0;
      for (int c = 0; c < 20000 && (acc_n < 2000 || b_exp.size() > 0); c++) begin
         b_out_ready = (acc_n >= 2000) ? 1'b1 : ($urandom_range(3) != 0);
         if (!b_in_valid && acc_n < 2000 && $urandom_range(3) != 0) begin
            if (acc_n == 0) begin
               b_in_a = 8'h80; b_in_b = 8'h80; b_in_signed = 1;
            end else if (acc_n == 1) begin
               b_in_a = 8'hFF; b_in_b = 8'hFF; b_in_signed = 0;
            end else begin
               b_in_a = 8'($urandom); b_in_b = 8'($urandom); b_in_signed = 1'($urandom);
            end
            b_in_valid = 1;
         end
         #1;
         if (b_out_valid && b_out_ready) begin
            if (b_exp.size() == 0) chk("t6_extra", {b_out_signed, b_out_product}, 17'h0_0000 ^ 17'h1_FFFF ^ {b_out_signed, b_out_product} ^ 17'h1_FFFF ^ 17'h1);
            else chk("t6_result", {b_out_signed, b_out_product}, b_exp.pop_front());
         end
         accept = b_in_valid && b_in_ready;
         if (accept) begin
            b_exp.push_back(model(b_in_a, b_in_b, b_in_signed));
            acc_n++;
         end
         step();
         if (accept) b_in_valid = 0;
      end
      chk("t6_accepted", 64'(acc_n), 64'(2000));
      chk("t6_drained", b_exp.size(), 0);
      chk("t6_corner_ss", model(8'h80, 8'h80, 1), {1'b1, 16'h4000});
      chk("t6_idle_busy", b_busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
